key_debounce_bank: RTL and testbench



---
 rtl/key_debounce_bank_pkg.sv | 27 ++
 rtl/key_debounce_bank_if.sv | 35 +++
 rtl/key_debounce_bank_one.sv | 142 ++++++++++++++
 rtl/key_debounce_bank.sv | 59 +++++
 tb/tb_key_debounce_bank.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_bank_pkg.sv
// Shared types and width helpers for the key debounce bank.
package key_pkg;

  // Per-key auto-repeat sequencing.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOLD = 2'd1,
    REPEAT    = 2'd2
  } rpt_state_t;

  // Bits needed for a counter that runs 0 .. max_count-1 (never narrower than 1).
  function automatic int unsigned cnt_width(input int unsigned max_count);
    int unsigned w;
    if (max_count <= 2) begin
      w = 1;
    end else begin
      w = $clog2(max_count);
    end
    return w;
  endfunction

  // Larger of two counts, used to size the shared hold/repeat counter.
  function automatic int unsigned max_count(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_bank_if.sv
// Key bank signal bundle: raw keys and pulse enable in, debounced levels and
// one-cycle pulses out. The slave side is the debounce bank itself.
interface key_debounce_bank_if #(
  parameter int unsigned NUM_KEYS = 6
);

  logic                en;
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_repeat;
  logic                any_press;

  modport master (
    output en,
    output key_n,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_repeat,
    input  any_press
  );

  modport slave (
    input  en,
    input  key_n,
    output key_level,
    output key_press,
    output key_release,
    output key_repeat,
    output any_press
  );

endinterface

// File: rtl/key_debounce_bank_one.sv
// One key: two-flop synchroniser, stability-count debounce, registered
// press/release pulses and a hold-to-repeat sequencer.
module key_debounce_one
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 1_000_000,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter bit          REPEAT_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat,
  output logic press_set
);

  localparam int unsigned DB_W = cnt_width(DB_CYCLES);
  localparam int unsigned HW   = cnt_width(max_count(HOLD_CYCLES, REPEAT_CYCLES));

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]   RPT_LAST  = HW'(REPEAT_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            sync2;
  logic [DB_W-1:0] db_cnt;
  logic            mismatch;
  logic            accept;
  logic            press_evt;
  logic            release_evt;
  logic            release_set;
  logic            repeat_set;

  rpt_state_t      state_q, state_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;

  // Two-flop synchroniser for the asynchronous raw key; resets to released.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], key_n};
    end
  end

  assign sync2 = ~sync_q[1];

  assign mismatch    = (sync2 != key_level);
  assign accept      = mismatch && (db_cnt == DB_LAST);
  assign press_evt   = accept && !key_level;
  assign release_evt = accept && key_level;
  assign press_set   = press_evt && en;
  assign release_set = release_evt && en;

  // Debounce: count consecutive mismatching samples; flip the level on the
  // DB_CYCLES-th one, clear on any agreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt    <= '0;
      key_level <= 1'b0;
    end else if (!mismatch) begin
      db_cnt    <= '0;
    end else if (accept) begin
      db_cnt    <= '0;
      key_level <= ~key_level;
    end else begin
      db_cnt    <= db_cnt + 1'b1;
    end
  end

  // Repeat sequencer state and hold/repeat interval counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Repeat next-state: en low or an accepted release abort to IDLE before
  // any interval check, so no repeat can share a cycle with a release.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    repeat_set = 1'b0;
    if (!en || release_evt) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          hold_cnt_d = '0;
          if (press_evt && REPEAT_EN) begin
            state_d = WAIT_HOLD;
          end
        end
        WAIT_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            repeat_set = 1'b1;
            state_d    = REPEAT;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (hold_cnt_q == RPT_LAST) begin
            repeat_set = 1'b1;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  // Registered one-cycle output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      key_press   <= press_set;
      key_release <= release_set;
      key_repeat  <= repeat_set;
    end
  end

endmodule

// File: rtl/key_debounce_bank.sv
// Bank of independent debounced keys feeding the stopwatch/timer. Each key
// is conditioned by key_debounce_one; any_press flags a press on any key.
module key_debounce_bank
  import key_pkg::*;
#(
  parameter int unsigned          NUM_KEYS      = 6,
  parameter int unsigned          DB_CYCLES     = 1_000_000,
  parameter int unsigned          HOLD_CYCLES   = 50_000_000,
  parameter int unsigned          REPEAT_CYCLES = 10_000_000,
  parameter logic [NUM_KEYS-1:0]  REPEAT_EN     = '0
) (
  input  logic              clk_50M,
  input  logic              rst,
  key_debounce_bank_if.slave bus
);

  logic [NUM_KEYS-1:0] level_vec;
  logic [NUM_KEYS-1:0] press_vec;
  logic [NUM_KEYS-1:0] release_vec;
  logic [NUM_KEYS-1:0] repeat_vec;
  logic [NUM_KEYS-1:0] press_set_vec;
  logic                any_press_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_one #(
      .DB_CYCLES     (DB_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .REPEAT_EN     (REPEAT_EN[i])
    ) u_key (
      .clk         (clk_50M),
      .rst         (rst),
      .en          (bus.en),
      .key_n       (bus.key_n[i]),
      .key_level   (level_vec[i]),
      .key_press   (press_vec[i]),
      .key_release (release_vec[i]),
      .key_repeat  (repeat_vec[i]),
      .press_set   (press_set_vec[i])
    );
  end

  // any_press registers the OR of the per-key press conditions on the same
  // edge that registers key_press, so the two stay cycle-aligned.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_set_vec;
    end
  end

  assign bus.key_level   = level_vec;
  assign bus.key_press   = press_vec;
  assign bus.key_release = release_vec;
  assign bus.key_repeat  = repeat_vec;
  assign bus.any_press   = any_press_q;

endmodule

// File: tb/tb_key_debounce_bank.sv
// Self-checking bench for key_debounce_bank: directed scenarios followed by
// random key activity, all compared each cycle against a window-based model.
module tb_key_debounce_bank;

  localparam int unsigned NK   = 6;
  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 20;
  localparam int unsigned RPT  = 8;
  localparam logic [NK-1:0] REN = 6'b000100;
  localparam int unsigned HD   = DB + 2;

  logic clk_50M = 1'b0;
  logic rst;

  always #10 clk_50M = ~clk_50M;

  key_debounce_bank_if #(.NUM_KEYS(NK)) bus ();

  key_debounce_bank #(
    .NUM_KEYS      (NK),
    .DB_CYCLES     (DB),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (RPT),
    .REPEAT_EN     (REN)
  ) dut (
    .clk_50M (clk_50M),
    .rst     (rst),
    .bus     (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: raw pressed samples per edge, newest at index 0.
  logic          m_hist [NK][HD];
  logic [NK-1:0] m_level, m_press, m_rel, m_rpt;
  logic          m_any;
  bit            m_armed [NK];
  int            m_tp [NK];
  int            edge_no = 0;

  // Observation bookkeeping for directed scenarios.
  int step;
  int n_press [NK];
  int n_rel   [NK];
  int n_rpt   [NK];
  int n_any;
  int first_press [NK];
  int first_any;
  int rpt_steps [$];

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      for (int j = 0; j < HD; j++) m_hist[k][j] = 1'b0;
      m_armed[k] = 1'b0;
      m_tp[k]    = 0;
    end
    m_level = '0; m_press = '0; m_rel = '0; m_rpt = '0; m_any = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present before it.
  // A level flips once the last DB synchronised samples all disagree with it;
  // synchronisation delays each raw sample by two edges.
  task automatic model_edge();
    logic flip, old;
    edge_no++;
    if (rst) begin
      model_reset();
    end else begin
      m_press = '0; m_rel = '0; m_rpt = '0;
      for (int k = 0; k < NK; k++) begin
        for (int j = HD - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
        m_hist[k][0] = ~bus.key_n[k];
        old  = m_level[k];
        flip = 1'b1;
        for (int j = 2; j < HD; j++) if (m_hist[k][j] == old) flip = 1'b0;
        m_press[k] = flip && !old && bus.en;
        m_rel[k]   = flip && old && bus.en;
        if (!bus.en || (flip && old)) begin
          m_armed[k] = 1'b0;
        end else if (flip && !old && REN[k]) begin
          m_armed[k] = 1'b1;
          m_tp[k]    = edge_no;
        end else if (m_armed[k] && (edge_no - m_tp[k]) >= int'(HOLD) &&
                     ((edge_no - m_tp[k] - int'(HOLD)) % int'(RPT)) == 0) begin
          m_rpt[k] = 1'b1;
        end
        if (flip) m_level[k] = ~old;
      end
      m_any = |m_press;
    end
  endtask

  task automatic check_all();
    checks++;
    assert (bus.key_level === m_level) else begin
      errors++; $error("FAIL level edge=%0d observed=%b expected=%b", edge_no, bus.key_level, m_level);
    end
    checks++;
    assert (bus.key_press === m_press) else begin
      errors++; $error("FAIL press edge=%0d observed=%b expected=%b", edge_no, bus.key_press, m_press);
    end
    checks++;
    assert (bus.key_release === m_rel) else begin
      errors++; $error("FAIL release edge=%0d observed=%b expected=%b", edge_no, bus.key_release, m_rel);
    end
    checks++;
    assert (bus.key_repeat === m_rpt) else begin
      errors++; $error("FAIL repeat edge=%0d observed=%b expected=%b", edge_no, bus.key_repeat, m_rpt);
    end
    checks++;
    assert (bus.any_press === m_any) else begin
      errors++; $error("FAIL any_press edge=%0d observed=%b expected=%b", edge_no, bus.any_press, m_any);
    end
  endtask

  task automatic expect_eq(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++; $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clear_obs();
    step = 0;
    n_any = 0;
    first_any = -1;
    rpt_steps.delete();
    for (int k = 0; k < NK; k++) begin
      n_press[k] = 0; n_rel[k] = 0; n_rpt[k] = 0; first_press[k] = -1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_50M);
    #1;
    step++;
    check_all();
    for (int k = 0; k < NK; k++) begin
      if (bus.key_press[k] === 1'b1) begin
        n_press[k]++;
        if (first_press[k] < 0) first_press[k] = step;
      end
      if (bus.key_release[k] === 1'b1) n_rel[k]++;
      if (bus.key_repeat[k] === 1'b1) n_rpt[k]++;
    end
    if (bus.key_repeat[2] === 1'b1) rpt_steps.push_back(step);
    if (bus.any_press === 1'b1) begin
      n_any++;
      if (first_any < 0) first_any = step;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int exp_rpt [5] = '{26, 34, 42, 50, 58};
    logic [NK-1:0] kn;
    model_reset();
    rst = 1'b1;
    bus.en = 1'b1;
    bus.key_n = '1;

    // 1. Reset with all keys released, then idle.
    clear_obs();
    ticks(10);
    expect_eq("reset_outputs", int'({bus.key_level, bus.key_press, bus.key_release, bus.key_repeat, bus.any_press}), 0);
    rst = 1'b0;
    clear_obs();
    ticks(50);
    expect_eq("idle_no_press", n_any, 0);

    // 2. Clean press and release on key 0.
    clear_obs();
    bus.key_n[0] = 1'b0;
    ticks(30);
    expect_eq("k0_press_count", n_press[0], 1);
    expect_eq("k0_press_step", first_press[0], 6);
    expect_eq("k0_level", int'(bus.key_level[0]), 1);
    clear_obs();
    bus.key_n[0] = 1'b1;
    ticks(30);
    expect_eq("k0_release_count", n_rel[0], 1);
    expect_eq("k0_repeat_count", n_rpt[0], 0);

    // 3. Bounce on key 1 must be rejected, then a steady press accepted.
    clear_obs();
    for (int r = 0; r < 5; r++) begin
      bus.key_n[1] = 1'b0; ticks(3);
      bus.key_n[1] = 1'b1; ticks(1);
    end
    ticks(4);
    expect_eq("k1_bounce_press", n_press[1], 0);
    expect_eq("k1_bounce_level", int'(bus.key_level[1]), 0);
    clear_obs();
    bus.key_n[1] = 1'b0;
    ticks(20);
    expect_eq("k1_steady_press", n_press[1], 1);
    bus.key_n[1] = 1'b1;
    ticks(20);

    // 4. Hold-to-repeat on key 2.
    clear_obs();
    bus.key_n[2] = 1'b0;
    ticks(60);
    expect_eq("k2_press_step", first_press[2], 6);
    expect_eq("k2_repeat_count", rpt_steps.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < rpt_steps.size()) expect_eq("k2_repeat_step", rpt_steps[i], exp_rpt[i]);
    end
    clear_obs();
    bus.key_n[2] = 1'b1;
    ticks(40);
    expect_eq("k2_release_count", n_rel[2], 1);
    expect_eq("k2_repeat_after_release", n_rpt[2], 0);

    // 5a. Press while pulses are disabled is lost.
    clear_obs();
    bus.en = 1'b0;
    bus.key_n[0] = 1'b0;
    ticks(20);
    expect_eq("en0_level", int'(bus.key_level[0]), 1);
    expect_eq("en0_press", n_press[0], 0);
    bus.en = 1'b1;
    bus.key_n[0] = 1'b1;
    ticks(20);

    // 5b. Simultaneous presses on keys 4 and 5.
    clear_obs();
    bus.key_n[4] = 1'b0;
    bus.key_n[5] = 1'b0;
    ticks(20);
    expect_eq("k4_press_step", first_press[4], 6);
    expect_eq("k5_press_step", first_press[5], 6);
    expect_eq("any_press_count", n_any, 1);
    expect_eq("any_press_step", first_any, 6);
    bus.key_n[4] = 1'b1;
    bus.key_n[5] = 1'b1;
    ticks(20);

    // 6. Reset during debounce with key 3 held through reset release.
    clear_obs();
    bus.key_n[3] = 1'b0;
    ticks(2);
    rst = 1'b1;
    ticks(1);
    rst = 1'b0;
    expect_eq("k3_no_press_pre_reset", n_press[3], 0);
    clear_obs();
    ticks(20);
    expect_eq("k3_press_step", first_press[3], 6);
    expect_eq("k3_press_count", n_press[3], 1);
    bus.key_n[3] = 1'b1;
    ticks(20);

    // Random key activity with occasional en drops and resets.
    kn = '1;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range((k == 2) ? 59 : 9, 0) == 0) kn[k] = ~kn[k];
      end
      bus.key_n = kn;
      if ($urandom_range(79, 0) == 0) bus.en = ~bus.en;
      if (!bus.en && $urandom_range(15, 0) == 0) bus.en = 1'b1;
      rst = ($urandom_range(499, 0) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
